// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode enum, flag struct and CLA group size for alu_pipe
// Contents: alu_op_e (3-bit opcodes), flags_t {n, z, v, c}, CLA_GRP.
package alu_pkg;

    localparam int CLA_GRP = 4;

    // Codes 3'b001 and 3'b111 are reserved and yield a zero result.
    typedef enum logic [2:0] {
        PASS = 3'b000,
        ADD  = 3'b010,
        SUB  = 3'b011,
        AND  = 3'b100,
        OR   = 3'b101,
        XOR  = 3'b110
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/cla_grp4.sv
// rtl/cla_grp4.sv - 4-bit carry-lookahead group producing carry-select sums
// Ports: a, bO (4-bit operands in); sum0/sum1 (4-bit sums for group
// carry-in 0/1 out); G, P (group generate/propagate out). Combinational.
module cla_grp4 (
    input  logic [3:0] a,
    input  logic [3:0] bO,
    output logic [3:0] sum0,
    output logic [3:0] sum1,
    output logic       G,
    output logic       P
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c0;   // carry into each bit with group carry-in 0
    logic [3:0] w_c1;   // carry into each bit with group carry-in 1

    assign w_g = a & bO;
    assign w_p = a ^ bO;

    assign w_c0[0] = 1'b0;
    assign w_c0[1] = w_g[0];
    assign w_c0[2] = w_g[1] | (w_p[1] & w_g[0]);
    assign w_c0[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]);

    assign w_c1[0] = 1'b1;
    assign w_c1[1] = w_g[0] | w_p[0];
    assign w_c1[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0]);
    assign w_c1[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0]);

    assign sum0 = w_p ^ w_c0;
    assign sum1 = w_p ^ w_c1;

    assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign P = &w_p;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined WIDTH-bit CLA ALU with valid/ready handshake
// Ports: clk, rst_n (async active-low); in_valid/in_ready, a, b, cntrl (input
// bundle); out_valid/out_ready, result, negative, zero, overflow, carry_out
// (output bundle). Macro ALU_FLAGS_EN enables the registered NZVC flags;
// without it the flag ports are tied to 0.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int NGRP = WIDTH / CLA_GRP;

    // ---------------- stage 1 ----------------
    logic [WIDTH-1:0] w_bo;
    logic [WIDTH-1:0] w_sum0;
    logic [WIDTH-1:0] w_sum1;
    logic [NGRP-1:0]  w_g;
    logic [NGRP-1:0]  w_p;
    logic             w_s2_stall;

    logic             r_s1_valid;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_bo;
    logic [WIDTH-1:0] r_sum0;
    logic [WIDTH-1:0] r_sum1;
    logic [NGRP-1:0]  r_g;
    logic [NGRP-1:0]  r_p;

    assign w_bo       = (cntrl == SUB) ? ~b : b;
    assign w_s2_stall = out_valid && !out_ready;
    // Stage 1 may load whenever it is empty or its content moves on to stage 2.
    assign in_ready   = !(r_s1_valid && w_s2_stall);

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        cla_grp4 u_grp (
            .a    (a[CLA_GRP*gi +: CLA_GRP]),
            .bO   (w_bo[CLA_GRP*gi +: CLA_GRP]),
            .sum0 (w_sum0[CLA_GRP*gi +: CLA_GRP]),
            .sum1 (w_sum1[CLA_GRP*gi +: CLA_GRP]),
            .G    (w_g[gi]),
            .P    (w_p[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_op       <= 3'b000;
            r_a        <= '0;
            r_bo       <= '0;
            r_sum0     <= '0;
            r_sum1     <= '0;
            r_g        <= '0;
            r_p        <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_op   <= cntrl;
                r_a    <= a;
                r_bo   <= w_bo;
                r_sum0 <= w_sum0;
                r_sum1 <= w_sum1;
                r_g    <= w_g;
                r_p    <= w_p;
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic [NGRP-1:0]  w_c;      // carry into each group
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_result;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;

    assign w_c[0] = (r_op == SUB);
    for (genvar ci = 0; ci < NGRP - 1; ci++) begin : g_carry
        assign w_c[ci+1] = r_g[ci] | (r_p[ci] & w_c[ci]);
    end

    for (genvar si = 0; si < NGRP; si++) begin : g_sel
        assign w_sum[CLA_GRP*si +: CLA_GRP] = w_c[si] ? r_sum1[CLA_GRP*si +: CLA_GRP]
                                                      : r_sum0[CLA_GRP*si +: CLA_GRP];
    end

    always_comb begin
        w_result = '0;
        case (r_op)
            PASS:    w_result = r_bo;
            ADD,
            SUB:     w_result = w_sum;
            AND:     w_result = r_a & r_bo;
            OR:      w_result = r_a | r_bo;
            XOR:     w_result = r_a ^ r_bo;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (!w_s2_stall) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_result;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;

`ifdef ALU_FLAGS_EN
    logic   w_cout;
    logic   w_cmsb;     // carry into bit WIDTH-1, recovered from a ^ bO ^ sum
    logic   w_arith;
    flags_t w_flags;
    flags_t r_flags;

    assign w_cout  = r_g[NGRP-1] | (r_p[NGRP-1] & w_c[NGRP-1]);
    assign w_cmsb  = r_a[WIDTH-1] ^ r_bo[WIDTH-1] ^ w_sum[WIDTH-1];
    assign w_arith = (r_op == ADD) || (r_op == SUB);

    always_comb begin
        w_flags   = '0;
        w_flags.n = w_result[WIDTH-1];
        w_flags.z = (w_result == '0);
        w_flags.v = w_arith & (w_cout ^ w_cmsb);
        w_flags.c = w_arith & w_cout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (!w_s2_stall && r_s1_valid) begin
            r_flags <= w_flags;
        end
    end

    assign negative  = r_flags.n;
    assign zero      = r_flags.z;
    assign overflow  = r_flags.v;
    assign carry_out = r_flags.c;
`else
    // The top group's G/P only feed the carry-out, which has no consumer here.
    logic w_unused_gp;
    assign w_unused_gp = ^{r_g[NGRP-1], r_p[NGRP-1]};

    assign negative  = 1'b0;
    assign zero      = 1'b0;
    assign overflow  = 1'b0;
    assign carry_out = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard testbench for alu_pipe at WIDTH=16
module tb_alu_pipe;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  cntrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        negative, zero, overflow, carry_out;

    logic [19:0] q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cntrl     (cntrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference: {n, z, v, c, result[15:0]}
    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic [2:0] op);
        logic [15:0] yb, r;
        logic [16:0] s;
        logic        n, z, v, c, arith;
        yb    = (op == OP_SUB) ? ~y : y;
        s     = {1'b0, x} + {1'b0, yb} + ((op == OP_SUB) ? 17'd1 : 17'd0);
        case (op)
            OP_PASS:       r = y;
            OP_ADD,
            OP_SUB:        r = s[15:0];
            OP_AND:        r = x & y;
            OP_OR:         r = x | y;
            OP_XOR:        r = x ^ y;
            default:       r = 16'h0000;
        endcase
        arith = (op == OP_ADD) || (op == OP_SUB);
        c     = arith & s[16];
        v     = arith & (x[15] == yb[15]) & (r[15] != x[15]);
        n     = r[15];
        z     = (r == 16'h0000);
`ifndef ALU_FLAGS_EN
        n = 1'b0; z = 1'b0; v = 1'b0; c = 1'b0;
`endif
        return {n, z, v, c, r};
    endfunction

    // One clock: check delivery and record accepts at the negedge, return at posedge+1.
    task automatic step();
        logic [19:0] exp;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_output result=%h expected no output", result);
            end else begin
                exp = q.pop_front();
                n_vec++;
                if (result !== exp[15:0]) begin
                    n_err++;
                    $display("FAIL result got=%h expected=%h", result, exp[15:0]);
                end
                n_vec++;
                if ({negative, zero, overflow, carry_out} !== exp[19:16]) begin
                    n_err++;
                    $display("FAIL flags_nzvc got=%b expected=%b",
                             {negative, zero, overflow, carry_out}, exp[19:16]);
                end
            end
        end
        if (rst_n && in_valid && in_ready) begin
            q.push_back(model(a, b, cntrl));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic [2:0] op);
        int acc0;
        acc0     = n_acc;
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        cntrl    = op;
        for (int i = 0; i < 20 && n_acc == acc0; i++) step();
        in_valid = 1'b0;
        if (n_acc == acc0) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout op=%b got no accept expected accept", op);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        step();
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b expected=0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b expected=1", in_ready); end
        n_vec++; if (result !== 16'h0) begin n_err++; $display("FAIL rst_result got=%h expected=0000", result); end
        n_vec++; if ({negative, zero, overflow, carry_out} !== 4'b0) begin
            n_err++; $display("FAIL rst_flags got=%b expected=0000", {negative, zero, overflow, carry_out});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_latency();
        send(16'h7FFF, 16'h0001, OP_ADD);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_early got=%b expected=0", out_valid); end
        step();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat_2cyc got=%b expected=1", out_valid); end
        drain();
    endtask

    task automatic test_arith();
        logic [15:0] ta[5] = '{16'h0003, 16'h0005, 16'h0FFF, 16'hFFFF, 16'h8000};
        logic [15:0] tb[5] = '{16'h0009, 16'h0005, 16'h0001, 16'h0001, 16'h0001};
        logic [2:0]  to[5] = '{OP_SUB,   OP_SUB,   OP_ADD,   OP_ADD,   OP_SUB};
        for (int i = 0; i < 5; i++) send(ta[i], tb[i], to[i]);
        drain();
    endtask

    task automatic test_logic();
        send(16'h00F0, 16'h0FF0, OP_AND);
        send(16'h00F0, 16'h0FF0, OP_OR);
        send(16'h00F0, 16'h0FF0, OP_XOR);
        send(16'hFFFF, 16'h1234, OP_PASS);
        send(16'hFFFF, 16'hFFFF, OP_RSV);
        send(16'h1234, 16'h5678, 3'b001);
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            send(16'($urandom), 16'($urandom), 3'($urandom_range(7, 0)));
        drain();
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, OP_ADD);
        send(16'h5555, 16'h0F0F, OP_XOR);
        in_valid = 1'b1;
        a        = 16'h0010;
        b        = 16'h0020;
        cntrl    = OP_SUB;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b expected=0", i, in_ready); end
            step();
        end
        n_vec++;
        if (q.size() != 2) begin n_err++; $display("FAIL bp_held_accepts got=%0d expected=2", q.size()); end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b expected=1", in_ready); end
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_rate cyc=%0d got=%b expected=1", i, out_valid); end
            step();
        end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%b expected=0", out_valid); end
        drain();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send(16'h7000, 16'h1000, OP_ADD);
        send(16'hAAAA, 16'h5555, OP_OR);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got=%b expected=0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready got=%b expected=1", in_ready); end
        n_vec++; if (result !== 16'h0) begin n_err++; $display("FAIL mid_result got=%h expected=0000", result); end
        n_vec++; if ({negative, zero, overflow, carry_out} !== 4'b0) begin
            n_err++; $display("FAIL mid_flags got=%b expected=0000", {negative, zero, overflow, carry_out});
        end
        q.delete();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        send(16'h1234, 16'h1111, OP_ADD);
        step();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_valid got=%b expected=1", out_valid); end
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_logic();
        test_back_pressure();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
